// File: rtl/adsr_envelope_poly.sv
// ============================================================================
// Module   : adsr_envelope_poly
// Brief    : Polyphonic ADSR envelope generator with shared runtime rates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_envelope_poly #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RATE_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tick_i,
  input  logic [NUM_CH-1:0]            gate_i,
  input  logic [RATE_WIDTH-1:0]        attack_rate_i,
  input  logic [RATE_WIDTH-1:0]        decay_rate_i,
  input  logic [DATA_WIDTH-2:0]        sustain_i,
  input  logic [RATE_WIDTH-1:0]        release_rate_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] envelope_o,
  output logic                         env_valid_o,
  output logic [NUM_CH-1:0]            active_o
);

  localparam int C_LW = DATA_WIDTH - 1;
  localparam int C_XW = DATA_WIDTH + 1;
  localparam logic [C_LW-1:0] C_MAX_L = {C_LW{1'b1}};
  localparam logic [C_XW-1:0] C_MAX_X = {2'b00, {C_LW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Shared operands widened so no comparison or sum can wrap.
  logic [C_XW-1:0] w_att_x;
  logic [C_XW-1:0] w_dec_x;
  logic [C_XW-1:0] w_rel_x;
  logic [C_XW-1:0] w_sus_x;
  logic [C_XW-1:0] w_dec_floor_x;
  logic            w_att_zero;
  logic            w_dec_zero;
  logic            w_rel_zero;

  assign w_att_x       = C_XW'(attack_rate_i);
  assign w_dec_x       = C_XW'(decay_rate_i);
  assign w_rel_x       = C_XW'(release_rate_i);
  assign w_sus_x       = C_XW'(sustain_i);
  assign w_dec_floor_x = w_sus_x + w_dec_x;
  assign w_att_zero    = (attack_rate_i == '0);
  assign w_dec_zero    = (decay_rate_i == '0);
  assign w_rel_zero    = (release_rate_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      env_valid_o <= 1'b0;
    end else begin
      env_valid_o <= tick_i;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t          r_state;
    logic [C_LW-1:0] r_level;
    logic            r_gate_q;
    logic            w_rise;
    logic [C_XW-1:0] w_lvl_x;
    logic [C_XW-1:0] w_att_sum;
    logic [C_LW-1:0] w_dec_diff;
    logic [C_LW-1:0] w_rel_diff;

    assign w_rise     = gate_i[c] & ~r_gate_q;
    assign w_lvl_x    = C_XW'(r_level);
    assign w_att_sum  = w_lvl_x + w_att_x;
    // Truncated differences are only consumed when the rate is below the level.
    assign w_dec_diff = r_level - w_dec_x[C_LW-1:0];
    assign w_rel_diff = r_level - w_rel_x[C_LW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state  <= S_IDLE;
        r_level  <= '0;
        r_gate_q <= 1'b0;
      end else if (tick_i) begin
        r_gate_q <= gate_i[c];
        case (r_state)
          S_IDLE: begin
            r_level <= '0;
            if (w_rise) begin
              r_state <= S_ATTACK;
            end
          end
          S_ATTACK: begin
            if (!gate_i[c]) begin
              r_state <= S_RELEASE;
            end else if (w_att_zero || (w_att_sum >= C_MAX_X)) begin
              r_level <= C_MAX_L;
              r_state <= S_DECAY;
            end else begin
              r_level <= w_att_sum[C_LW-1:0];
            end
          end
          S_DECAY: begin
            // Covers level already at/below a freshly raised sustain level too.
            if (!gate_i[c]) begin
              r_state <= S_RELEASE;
            end else if (w_dec_zero || (w_lvl_x <= w_dec_floor_x)) begin
              r_level <= sustain_i;
              r_state <= S_SUSTAIN;
            end else begin
              r_level <= w_dec_diff;
            end
          end
          S_SUSTAIN: begin
            if (!gate_i[c]) begin
              r_state <= S_RELEASE;
            end else begin
              r_level <= sustain_i;
            end
          end
          S_RELEASE: begin
            if (w_rise) begin
              r_state <= S_ATTACK;
            end else if (w_rel_zero || (w_lvl_x <= w_rel_x)) begin
              r_level <= '0;
              r_state <= S_IDLE;
            end else begin
              r_level <= w_rel_diff;
            end
          end
          default: begin
            r_level <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end

    assign envelope_o[c*DATA_WIDTH +: DATA_WIDTH] = {1'b0, r_level};
    assign active_o[c] = (r_state != S_IDLE);
  end

endmodule

`default_nettype wire
